pipe_alu_core: RTL and testbench
================================

Name: pipe_alu_core

Overview:
- Parametrised, pipelined integer arithmetic/shift unit; successor to the single-cycle 32-bit adder/shifter primitives.
- Carry-lookahead chain is split across STAGES register ranks for timing closure.
- Valid/ready handshake on both sides; results return in order with full backpressure.
- Sits in the RV32I execute stage and can be reused for address generation.

Parameters:
- WIDTH, 32, operand/result width; must be a multiple of BLK.
- BLK, 4, carry-lookahead block width in bits.
- STAGES, 2, pipeline register ranks, at least 1; (WIDTH/BLK) must divide evenly by STAGES, otherwise elaboration error.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  operation offered
- in_ready  out  1  unit accepts operation this cycle
- in_op  in  3  opcode (alu_pkg)
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B / shift amount (low $clog2(WIDTH) bits)
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_data  out  WIDTH  result
- out_cout  out  1  adder carry-out
- out_zero  out  1  out_data == 0
- out_ovf  out  1  signed overflow

Behaviour:
- Interface: one clock clk; reset rst is synchronous and active-high.
- Reset: all stage valid bits cleared; out_valid=0; out_data, out_cout, out_zero, out_ovf=0; in_ready=1 in the first cycle after reset.
- Mid-operation reset: all in-flight ops are discarded and no result is emitted for them.
- Opcodes:
  - 000 ADD: A+B
  - 001 SUB: A+~B+1
  - 010 SLL
  - 011 SRL
  - 100 SRA
  - 101/110: see Optional Feature
  - Undefined opcodes: result 0, cout=0, ovf=0, zero=1.
- Adder structure:
  - WIDTH/BLK CLA blocks in total.
  - Stage i evaluates blocks [i*N, (i+1)*N), where N=(WIDTH/BLK)/STAGES.
  - Stage i uses the carry registered from stage i-1; for stage 0 the carry-in is 1 for SUB, else 0.
  - Partial sums, operands, op and carry are forwarded rank to rank.
- Shifts: computed fully in stage 0 from in_a and the shift amount, then carried unchanged through the remaining ranks. Latency is identical for all ops.
- Flags:
  - cout = final carry (for SUB, 1 = no borrow).
  - ovf = (a_msb==b'_msb) && (sum_msb!=a_msb), where b' = B for ADD and ~B for SUB.
  - For shifts, cout=0 and ovf=0.
  - zero is evaluated on the final result in the last stage.
- Handshake:
  - An op is accepted on a rising edge with in_valid && in_ready.
  - Rank i advances when its valid bit is set and rank i+1 is empty or advancing; the last rank advances when out_ready=1.
  - in_ready = !valid[0] || advance[0]. This is combinational from out_ready; no skid buffer.
- Latency: with out_ready held high, an op accepted at edge k gives out_valid=1 in the cycle after edge k+STAGES-1. Throughput is 1 op/cycle.
- Stall: while out_valid && !out_ready, out_data and all flags hold stable; no op is lost or reordered.
- Simultaneous accept at the input and drain at the output in a full pipe: both occur in the same cycle, and occupancy stays constant.
- Wrap-around: ADD/SUB wrap modulo 2^WIDTH. Shift amount ≥ WIDTH cannot occur because only the low bits are used.

Optional Feature:
- Macro: PIPE_ALU_CMP_EN.
- When defined:
  - 101 SLT: result 1 when A<B signed (via sub: sum_msb ^ ovf), else 0.
  - 110 SLTU: result 1 when !cout of A-B, else 0.
  - Both ops take the SUB path internally; reported cout/ovf are those of the subtraction.
- When undefined: 101 and 110 are treated as undefined opcodes (result 0, zero=1).

Decomposition:
- Package alu_pkg:
  - opcode localparams OP_ADD, OP_SUB, OP_SLL, OP_SRL, OP_SRA, OP_SLT, OP_SLTU;
  - op width constant (3);
  - typedef for a stage record (valid, op, a, b', partial sum, carry, shift result).
- Sub-module cla_block: parametrised BLK-bit generate/propagate carry-lookahead adder (a, b, cin -> s, cout), instantiated N times per stage in a generate loop.

Test Plan:
- ADD 0x7FFFFFFF + 0x00000001, out_ready=1 -> 0x80000000, ovf=1, cout=0, zero=0, out_valid exactly STAGES cycles after accept.
- SUB 5-5 -> 0x00000000, zero=1, cout=1, ovf=0; SUB 0-1 -> 0xFFFFFFFF, cout=0.
- SRA 0x80000000 by 31 -> 0xFFFFFFFF; SRL same -> 0x00000001; SLL 0x1 by 33 (amount 1) -> 0x00000002.
- Backpressure (STAGES=2): issue 4 ADDs every cycle with out_ready=0 -> in_ready drops after 2 accepts; raise out_ready -> all 4 results emerge in order; output held stable while stalled.
- Reset mid-flight: accept 2 ops, assert rst for 1 cycle -> out_valid stays 0, no stale result, in_ready=1 in the next cycle.
- With PIPE_ALU_CMP_EN: SLT 0xFFFFFFFF,1 -> 1; SLTU same operands -> 0. Without the macro, op 101 -> 0 with zero=1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode encodings and stage control record for pipe_alu_core.
// PIPE_ALU_CMP_EN enables the SLT/SLTU compare opcodes.
package alu_pkg;

  localparam int OP_W = 3;

  typedef logic [OP_W-1:0] op_t;

  localparam op_t OP_ADD  = 3'b000;
  localparam op_t OP_SUB  = 3'b001;
  localparam op_t OP_SLL  = 3'b010;
  localparam op_t OP_SRL  = 3'b011;
  localparam op_t OP_SRA  = 3'b100;
  localparam op_t OP_SLT  = 3'b101;
  localparam op_t OP_SLTU = 3'b110;

  // Control half of a pipeline rank; the data half is sized by WIDTH in the core.
  typedef struct packed {
    op_t  op;
    logic carry;
  } stage_ctl_t;

  // Ops that run through the adder as A + ~B + 1.
  function automatic logic uses_sub(input op_t op);
`ifdef PIPE_ALU_CMP_EN
    return (op == OP_SUB) || (op == OP_SLT) || (op == OP_SLTU);
`else
    return op == OP_SUB;
`endif
  endfunction

endpackage

// File: rtl/cla_block.sv
// BLK-bit generate/propagate carry-lookahead adder slice.
module cla_block #(
  parameter int BLK = 4
) (
  input  logic [BLK-1:0] a,
  input  logic [BLK-1:0] b,
  input  logic           cin,
  output logic [BLK-1:0] s,
  output logic           cout
);

  logic [BLK-1:0] g;
  logic [BLK-1:0] p;
  logic [BLK:0]   c;
  logic           acc;

  assign g = a & b;
  assign p = a ^ b;

  // Each carry is formed independently from g/p and cin (flattened lookahead).
  always_comb begin
    c   = '0;
    acc = 1'b0;
    for (int k = 0; k <= BLK; k++) begin
      acc = cin;
      for (int j = 0; j < k; j++) begin
        acc = g[j] | (p[j] & acc);
      end
      c[k] = acc;
    end
  end

  assign s    = p ^ c[BLK-1:0];
  assign cout = c[BLK];

endmodule

// File: rtl/pipe_alu_core.sv
// Pipelined add/sub/shift unit: CLA chain split over STAGES ranks, valid/ready on both sides.
// Optional compare ops (SLT/SLTU) are built when PIPE_ALU_CMP_EN is defined.
module pipe_alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int BLK    = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_cout,
  output logic             out_zero,
  output logic             out_ovf
);

  localparam int NBLK = WIDTH / BLK;
  localparam int N    = NBLK / STAGES;
  localparam int SEG  = N * BLK;
  localparam int SW   = $clog2(WIDTH);

  if ((STAGES < 1) || (WIDTH % BLK != 0) || (NBLK % STAGES != 0)) begin : g_param_check
    $error("pipe_alu_core: WIDTH/BLK must be integral and divisible by STAGES >= 1");
  end

  // b holds B' (B or ~B); sum fills in SEG bits per rank, low segment first.
  typedef struct packed {
    stage_ctl_t       ctl;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] sh;
  } stage_t;

  // Handshake contract: a transfer happens on a rising edge where valid && ready;
  // in_ready depends combinationally on out_ready through the advance chain.
  stage_t                r [STAGES];
  stage_t [STAGES-1:0]   nxt;
  logic   [STAGES-1:0]   vld;
  logic   [STAGES-1:0]   adv;
  logic   [STAGES-1:0]   ld;
  logic                  full_above;

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    stage_t           src;
    stage_t           nx;
    logic [SEG-1:0]   s_part;

    if (i == 0) begin : g_first
      logic [SW-1:0] amt;
      always_comb begin
        amt           = in_b[SW-1:0];
        src           = '0;
        src.ctl.op    = in_op;
        src.ctl.carry = uses_sub(in_op);
        src.a         = in_a;
        src.b         = uses_sub(in_op) ? ~in_b : in_b;
        case (in_op)
          OP_SLL:  src.sh = in_a << amt;
          OP_SRL:  src.sh = in_a >> amt;
          OP_SRA:  src.sh = $unsigned($signed(in_a) >>> amt);
          default: src.sh = '0;
        endcase
      end
    end else begin : g_rest
      assign src = r[i-1];
    end

    for (genvar j = 0; j < N; j++) begin : g_blk
      logic bcin;
      logic bcout;
      if (j == 0) begin : g_c0
        assign bcin = src.ctl.carry;
      end else begin : g_cn
        assign bcin = g_blk[j-1].bcout;
      end
      cla_block #(.BLK(BLK)) u_cla (
        .a    (src.a[(i*N+j)*BLK +: BLK]),
        .b    (src.b[(i*N+j)*BLK +: BLK]),
        .cin  (bcin),
        .s    (s_part[j*BLK +: BLK]),
        .cout (bcout)
      );
    end

    always_comb begin
      nx                  = src;
      nx.sum[i*SEG +: SEG] = s_part;
      nx.ctl.carry        = g_blk[N-1].bcout;
    end

    assign nxt[i] = nx;
  end

  // A rank advances when it is valid and some rank above it is empty or the output drains.
  always_comb begin
    adv        = '0;
    full_above = 1'b1;
    for (int i = STAGES - 1; i >= 0; i--) begin
      adv[i]     = vld[i] && (out_ready || !full_above);
      full_above = full_above && vld[i];
    end
  end

  assign in_ready = !vld[0] || adv[0];

  always_comb begin
    ld    = '0;
    ld[0] = in_valid && in_ready;
    for (int i = 1; i < STAGES; i++) begin
      ld[i] = adv[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
      for (int i = 0; i < STAGES; i++) begin
        r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        if (ld[i]) begin
          r[i]   <= nxt[i];
          vld[i] <= 1'b1;
        end else if (adv[i]) begin
          vld[i] <= 1'b0;
        end
      end
    end
  end

  logic [WIDTH-1:0] res;
  logic             res_cout;
  logic             res_ovf;
  logic             add_ovf;

  always_comb begin
    add_ovf  = (r[STAGES-1].a[WIDTH-1] == r[STAGES-1].b[WIDTH-1]) &&
               (r[STAGES-1].sum[WIDTH-1] != r[STAGES-1].a[WIDTH-1]);
    res      = '0;
    res_cout = 1'b0;
    res_ovf  = 1'b0;
    case (r[STAGES-1].ctl.op)
      OP_ADD, OP_SUB: begin
        res      = r[STAGES-1].sum;
        res_cout = r[STAGES-1].ctl.carry;
        res_ovf  = add_ovf;
      end
      OP_SLL, OP_SRL, OP_SRA: res = r[STAGES-1].sh;
`ifdef PIPE_ALU_CMP_EN
      OP_SLT: begin
        res[0]   = r[STAGES-1].sum[WIDTH-1] ^ add_ovf;
        res_cout = r[STAGES-1].ctl.carry;
        res_ovf  = add_ovf;
      end
      OP_SLTU: begin
        res[0]   = !r[STAGES-1].ctl.carry;
        res_cout = r[STAGES-1].ctl.carry;
        res_ovf  = add_ovf;
      end
`endif
      default: res = '0;
    endcase
  end

  // Outputs read as zero whenever the last rank is empty.
  assign out_valid = vld[STAGES-1];
  assign out_data  = out_valid ? res : '0;
  assign out_cout  = out_valid && res_cout;
  assign out_ovf   = out_valid && res_ovf;
  assign out_zero  = out_valid && (res == '0);

endmodule

// File: tb/tb_pipe_alu_core.sv
// Self-checking bench for pipe_alu_core (default WIDTH=32, BLK=4, STAGES=2).
module tb_pipe_alu_core;
  import alu_pkg::*;

  localparam int W      = 32;
  localparam int STAGES = 2;
  localparam int SW     = $clog2(W);
  localparam longint SMAX = (longint'(1) <<< (W - 1)) - 1;
  localparam longint SMIN = -(longint'(1) <<< (W - 1));

  typedef logic [W+2:0] exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [2:0]   in_op = 3'd0;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic         out_cout;
  logic         out_zero;
  logic         out_ovf;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_out    = 0;
  bit   rand_bp  = 1'b0;

  always #5 clk = ~clk;

  pipe_alu_core #(.WIDTH(W), .BLK(4), .STAGES(STAGES)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_cout  (out_cout),
    .out_zero  (out_zero),
    .out_ovf   (out_ovf)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic exp_t mk(input logic [W-1:0] d, input logic co, input logic z, input logic ov);
    return {d, co, z, ov};
  endfunction

  // Reference: plain integer arithmetic on the operands.
  function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb, ua, ub, rr;
    logic [W-1:0] d;
    logic co, ov;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    d  = '0;
    co = 1'b0;
    ov = 1'b0;
    case (op)
      OP_ADD: begin
        d  = a + b;
        co = ((ua + ub) >> W) != 0;
        rr = sa + sb;
        ov = (rr > SMAX) || (rr < SMIN);
      end
      OP_SUB: begin
        d  = a - b;
        co = ua >= ub;
        rr = sa - sb;
        ov = (rr > SMAX) || (rr < SMIN);
      end
      OP_SLL: d = a << b[SW-1:0];
      OP_SRL: d = a >> b[SW-1:0];
      OP_SRA: d = $unsigned($signed(a) >>> b[SW-1:0]);
`ifdef PIPE_ALU_CMP_EN
      OP_SLT, OP_SLTU: begin
        d  = '0;
        d[0] = (op == OP_SLT) ? (sa < sb) : (ua < ub);
        co = ua >= ub;
        rr = sa - sb;
        ov = (rr > SMAX) || (rr < SMIN);
      end
`endif
      default: d = '0;
    endcase
    return {d, co, (d == '0), ov};
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return {1'b1, {(W-1){1'b0}}};
      3:       return {1'b0, {(W-1){1'b1}}};
      4:       return W'($urandom_range(0, 40));
      default: return W'($urandom);
    endcase
  endfunction

  // Offer one op and hold it until accepted; the expected entry is queued at acceptance.
  task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input exp_t e, input bit use_e);
    bit done;
    done = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
    for (int c = 0; c < 200 && !done; c++) begin
      #3;
      if (in_ready) begin
        exp_q.push_back(use_e ? e : model(op, a, b));
        done = 1'b1;
      end else begin
        @(negedge clk);
        if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
      end
    end
    if (!done) chk("send_timeout", 64'(in_ready), 64'd1);
  endtask

  task automatic drain();
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 50 && exp_q.size() != 0; c++) @(negedge clk);
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  // Output scoreboard: every valid output must match the oldest outstanding result.
  always @(negedge clk) begin
    #3;
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out", 64'(out_valid), 64'd0);
      end else begin
        chk("result", 64'({out_data, out_cout, out_zero, out_ovf}), 64'(exp_q[0]));
        if (out_ready) begin
          void'(exp_q.pop_front());
          n_out++;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired with %0d results outstanding", exp_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] bpa [4];
    logic [W-1:0] bpb [4];
    int idx;
    int n_out0;

    // Reset
    repeat (3) @(negedge clk);
    #3;
    chk("in_reset_out_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    rst       = 1'b0;
    out_ready = 1'b1;
    #3;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_outputs", 64'({out_data, out_cout, out_zero, out_ovf}), 64'd0);

    // Latency with signed overflow on ADD
    send(OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, mk(32'h8000_0000, 1'b0, 1'b0, 1'b1), 1'b1);
    for (int c = 1; c < STAGES; c++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #3;
      chk("lat_early", 64'(out_valid), 64'd0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    #3;
    chk("lat_valid", 64'(out_valid), 64'd1);

    // Directed corner values, back to back
    send(OP_SUB, 32'd5, 32'd5, mk(32'h0000_0000, 1'b1, 1'b1, 1'b0), 1'b1);
    send(OP_SUB, 32'd0, 32'd1, mk(32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0), 1'b1);
    send(OP_SRA, 32'h8000_0000, 32'd31, mk(32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0), 1'b1);
    send(OP_SRL, 32'h8000_0000, 32'd31, mk(32'h0000_0001, 1'b0, 1'b0, 1'b0), 1'b1);
    send(OP_SLL, 32'h0000_0001, 32'd33, mk(32'h0000_0002, 1'b0, 1'b0, 1'b0), 1'b1);
    send(OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, mk(32'h0000_0000, 1'b1, 1'b1, 1'b0), 1'b1);
    send(OP_SUB, 32'h8000_0000, 32'h0000_0001, mk(32'h7FFF_FFFF, 1'b1, 1'b0, 1'b1), 1'b1);
`ifdef PIPE_ALU_CMP_EN
    send(OP_SLT,  32'hFFFF_FFFF, 32'd1, mk(32'h0000_0001, 1'b1, 1'b0, 1'b0), 1'b1);
    send(OP_SLTU, 32'hFFFF_FFFF, 32'd1, mk(32'h0000_0000, 1'b1, 1'b1, 1'b0), 1'b1);
`else
    send(3'b101, 32'hFFFF_FFFF, 32'd1, mk(32'h0000_0000, 1'b0, 1'b1, 1'b0), 1'b1);
    send(3'b110, 32'hFFFF_FFFF, 32'd1, mk(32'h0000_0000, 1'b0, 1'b1, 1'b0), 1'b1);
`endif
    send(3'b111, 32'h1234_5678, 32'h9ABC_DEF0, mk(32'h0000_0000, 1'b0, 1'b1, 1'b0), 1'b1);
    drain();

    // Backpressure: pipe fills after STAGES accepts, then drains in order
    for (int k = 0; k < 4; k++) begin
      bpa[k] = $urandom;
      bpb[k] = $urandom;
    end
    idx    = 0;
    n_out0 = n_out;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      out_ready = 1'b0;
      if (idx < 4) begin
        in_valid = 1'b1;
        in_op    = OP_ADD;
        in_a     = bpa[idx];
        in_b     = bpb[idx];
      end
      #3;
      if (in_ready && idx < 4) begin
        exp_q.push_back(model(OP_ADD, bpa[idx], bpb[idx]));
        idx++;
      end
    end
    chk("bp_accepts", 64'(idx), 64'(STAGES));
    chk("bp_in_ready_low", 64'(in_ready), 64'd0);
    repeat (2) begin
      @(negedge clk);
      #3;
      chk("bp_stall_valid", 64'(out_valid), 64'd1);
    end
    for (int c = 0; c < 20 && idx < 4; c++) begin
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_op     = OP_ADD;
      in_a      = bpa[idx];
      in_b      = bpb[idx];
      #3;
      if (in_ready) begin
        exp_q.push_back(model(OP_ADD, bpa[idx], bpb[idx]));
        idx++;
      end
    end
    chk("bp_all_sent", 64'(idx), 64'd4);
    drain();
    chk("bp_outputs", 64'(n_out - n_out0), 64'd4);

    // Reset with ops in flight
    @(negedge clk);
    out_ready = 1'b0;
    send(OP_ADD, $urandom, $urandom, '0, 1'b0);
    send(OP_SUB, $urandom, $urandom, '0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    out_ready = 1'b1;
    #3;
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    repeat (4) begin
      @(negedge clk);
      #3;
      chk("mid_rst_no_stale", 64'(out_valid), 64'd0);
    end

    // Random ops with random backpressure
    rand_bp = 1'b1;
    for (int k = 0; k < 300; k++) begin
      send(3'($urandom_range(0, 7)), pick(), pick(), '0, 1'b0);
      if ($urandom_range(0, 4) == 0) begin
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = ($urandom_range(0, 3) != 0);
      end
    end
    rand_bp = 1'b0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
